mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared memory port.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_wstrb,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, IF_XFER, DM_XFER, RESP} state_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

    state_t      state_reg, state_next;
    logic        owner_if_reg, owner_if_next;
    logic        we_reg, we_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  wstrb_reg, wstrb_next;
    logic [31:0] if_rdata_reg, if_rdata_next;
    logic [31:0] dm_rdata_reg, dm_rdata_next;
    logic        grant_if;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_reg, starve_cnt_next;

    // Fetch normally loses to data, but wins once the data side has had its quota.
    assign grant_if = if_req && (!dm_req || starve_cnt_reg == LIMIT);

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (state_reg == IDLE && (if_req || dm_req)) begin
            if (grant_if || !if_req) begin
                starve_cnt_next = 4'd0;
            end else begin
                starve_cnt_next = starve_cnt_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= 4'd0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`else
    assign grant_if = if_req && !dm_req;
`endif

    always_comb begin
        state_next    = state_reg;
        owner_if_next = owner_if_reg;
        we_next       = we_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        wstrb_next    = wstrb_reg;
        if_rdata_next = if_rdata_reg;
        dm_rdata_next = dm_rdata_reg;
        case (state_reg)
            IDLE: begin
                if (if_req || dm_req) begin
                    owner_if_next = grant_if;
                    if (grant_if) begin
                        addr_next  = if_addr;
                        we_next    = 1'b0;
                        wdata_next = 32'd0;
                        wstrb_next = 4'b0000;
                        state_next = IF_XFER;
                    end else begin
                        addr_next  = dm_addr;
                        we_next    = dm_we;
                        wdata_next = dm_wdata;
                        wstrb_next = dm_wstrb;
                        state_next = DM_XFER;
                    end
                end
            end
            IF_XFER: begin
                if (mem_ack) begin
                    if_rdata_next = mem_rdata;
                    state_next    = RESP;
                end
            end
            DM_XFER: begin
                if (mem_ack) begin
                    if (!we_reg) begin
                        dm_rdata_next = mem_rdata;
                    end
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            owner_if_reg <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            wstrb_reg    <= 4'd0;
            if_rdata_reg <= 32'd0;
            dm_rdata_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            owner_if_reg <= owner_if_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            wstrb_reg    <= wstrb_next;
            if_rdata_reg <= if_rdata_next;
            dm_rdata_reg <= dm_rdata_next;
        end
    end

    // Control outputs decode straight from state so reset drops them without waiting for a clock.
    assign mem_req   = (state_reg == IF_XFER) || (state_reg == DM_XFER);
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_wstrb = wstrb_reg;
    assign if_valid  = (state_reg == RESP) && owner_if_reg;
    assign dm_valid  = (state_reg == RESP) && !owner_if_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants/responses, a monitor checks them.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_exp_t;

    typedef struct {
        logic        is_if;
        logic [31:0] rdata;
    } resp_exp_t;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];
    int        total = 0;
    int        bad = 0;
    int        ack_delay = 2;
    logic      stray_ack = 1'b0;

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h00A0_0093;
            32'h0000_0104: return 32'h1111_1111;
            32'h0000_3000: return 32'hCAFE_F00D;
            default:       return 32'hBAD0_BAD0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_exp_t e;
        e.we = we; e.addr = a; e.wdata = d; e.wstrb = s;
        mem_q.push_back(e);
    endtask

    task automatic push_resp(input logic is_if, input logic [31:0] d);
        resp_exp_t r;
        r.is_if = is_if; r.rdata = d;
        resp_q.push_back(r);
    endtask

    task automatic wait_valid(input bit want_if, input int maxc, output int cycles);
        cycles = 0;
        do begin
            cyc();
            cycles++;
        end while (!(want_if ? if_valid : dm_valid) && cycles < maxc);
        if (!(want_if ? if_valid : dm_valid)) begin
            total++;
            bad++;
            $display("FAIL wait_valid_timeout want_if=%0d after %0d cycles", want_if, cycles);
        end
    endtask

    // Memory model: acks after ack_delay cycles of mem_req, plus an optional injected stray ack.
    initial begin : responder
        int xfer_cyc;
        xfer_cyc  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = stray_ack;
            if (mem_req) begin
                xfer_cyc++;
                if (xfer_cyc == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_lookup(mem_addr);
                    xfer_cyc  = 0;
                end
            end else begin
                xfer_cyc = 0;
            end
        end
    end

    initial begin : monitor
        logic      prev_req;
        mem_exp_t  cur;
        resp_exp_t r;
        prev_req = 1'b0;
        cur.we = 1'b0; cur.addr = 32'd0; cur.wdata = 32'd0; cur.wstrb = 4'd0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_req && !prev_req) begin
                    if (mem_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_grant actual addr=%h we=%0d required none", mem_addr, mem_we);
                    end else begin
                        cur = mem_q.pop_front();
                        $display("grant addr=%h we=%0d wstrb=%h", mem_addr, mem_we, mem_wstrb);
                        check("grant_addr", mem_addr, cur.addr);
                        check("grant_we", {31'd0, mem_we}, {31'd0, cur.we});
                        check("grant_wstrb", {28'd0, mem_wstrb}, {28'd0, cur.wstrb});
                        if (cur.we) check("grant_wdata", mem_wdata, cur.wdata);
                    end
                end else if (mem_req) begin
                    check("hold_addr", mem_addr, cur.addr);
                end
                if (if_valid || dm_valid) begin
                    if (resp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_valid actual if=%0d dm=%0d required none", if_valid, dm_valid);
                    end else begin
                        r = resp_q.pop_front();
                        $display("valid if=%0d dm=%0d if_rdata=%h dm_rdata=%h", if_valid, dm_valid, if_rdata, dm_rdata);
                        check("valid_owner", {30'd0, if_valid, dm_valid}, r.is_if ? 32'd2 : 32'd1);
                        check("resp_rdata", r.is_if ? if_rdata : dm_rdata, r.rdata);
                    end
                end
            end
            prev_req = mem_req;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        int fetch_slot;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_wstrb = 4'd0;
        repeat (3) cyc();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valids", {30'd0, if_valid, dm_valid}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Single fetch, ack in second transfer cycle; request held one cycle past RESP.
        ack_delay = 2;
        push_mem(1'b0, 32'h100, 32'd0, 4'h0);
        push_resp(1'b1, 32'h00A0_0093);
        if_req = 1'b1; if_addr = 32'h100;
        wait_valid(1'b1, 20, n);
        check("fetch_latency", n, 32'd3);
        cyc();
        check("no_reissue_mem_req", {31'd0, mem_req}, 32'd0);
        if_req = 1'b0;
        cyc();
        check("no_reissue_busy", {31'd0, busy}, 32'd0);

        // Simultaneous requests: data write first, then fetch.
        push_mem(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF);
        push_resp(1'b0, 32'd0);
        push_mem(1'b0, 32'h104, 32'd0, 4'h0);
        push_resp(1'b1, 32'h1111_1111);
        if_req = 1'b1; if_addr = 32'h104;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
        wait_valid(1'b0, 20, n);
        dm_req = 1'b0;
        wait_valid(1'b1, 20, n);
        if_req = 1'b0;
        check("write_keeps_rdata", dm_rdata, 32'd0);
        cyc();

        // Data read with immediate ack, then a partial write that must not touch dm_rdata.
        ack_delay = 1;
        push_mem(1'b0, 32'h3000, 32'd0, 4'h0);
        push_resp(1'b0, 32'hCAFE_F00D);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; dm_wdata = 32'd0; dm_wstrb = 4'h0;
        wait_valid(1'b0, 20, n);
        check("read_latency", n, 32'd2);
        dm_req = 1'b0;
        cyc();
        push_mem(1'b1, 32'h2004, 32'h1234_5678, 4'h3);
        push_resp(1'b0, 32'hCAFE_F00D);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'h1234_5678; dm_wstrb = 4'h3;
        wait_valid(1'b0, 20, n);
        dm_req = 1'b0;
        cyc();
        check("rdata_after_write", dm_rdata, 32'hCAFE_F00D);

        // Stray ack in IDLE must do nothing.
        @(posedge clk); #3 stray_ack = 1'b1;
        @(posedge clk); #3 stray_ack = 1'b0;
        cyc();
        check("stray_busy", {31'd0, busy}, 32'd0);
        check("stray_mem_req", {31'd0, mem_req}, 32'd0);
        cyc();

        // Both requesters held continuously for ten transfers.
        ack_delay = 1;
`ifdef ARB_STARVE_GUARD_EN
        fetch_slot = 4;
`else
        fetch_slot = -1;
`endif
        for (int i = 0; i < 10; i++) begin
            if (fetch_slot >= 0 && (i % (fetch_slot + 1)) == fetch_slot) begin
                push_mem(1'b0, 32'h104, 32'd0, 4'h0);
                push_resp(1'b1, 32'h1111_1111);
            end else begin
                push_mem(1'b0, 32'h3000, 32'd0, 4'h0);
                push_resp(1'b0, 32'hCAFE_F00D);
            end
        end
        if_req = 1'b1; if_addr = 32'h104;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; dm_wstrb = 4'h0;
        for (int i = 0; i < 10; i++) begin
            n = 0;
            do begin
                cyc();
                n++;
            end while (!(if_valid || dm_valid) && n < 20);
            if (!(if_valid || dm_valid)) begin
                total++;
                bad++;
                $display("FAIL starve_wait_timeout actual=no_valid required=valid at transfer %0d", i);
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        cyc();
        cyc();

        // Reset during a data transfer, fetch still held afterwards.
        ack_delay = 5;
        push_mem(1'b1, 32'h2008, 32'hA5A5_A5A5, 4'hF);
        if_req = 1'b1; if_addr = 32'h100;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2008; dm_wdata = 32'hA5A5_A5A5; dm_wstrb = 4'hF;
        cyc();
        cyc();
        check("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_dm_valid", {31'd0, dm_valid}, 32'd0);
        dm_req = 1'b0;
        cyc();
        cyc();
        check("rst_clears_dm_rdata", dm_rdata, 32'd0);
        ack_delay = 2;
        push_mem(1'b0, 32'h100, 32'd0, 4'h0);
        push_resp(1'b1, 32'h00A0_0093);
        rst_n = 1'b1;
        wait_valid(1'b1, 20, n);
        check("post_reset_latency", n, 32'd3);
        if_req = 1'b0;
        repeat (3) cyc();

        check("mem_q_drained", mem_q.size(), 32'd0);
        check("resp_q_drained", resp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
